// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - walks a {reg_addr, value} table through the I2C byte-write engine
// Optional feature macro: SEQ_RETRY_LIMIT_EN (bounded ACK retries, error output and S_FAIL)
module i2c_reg_sequencer #(
    parameter int         NUM_CMDS    = 24,
    parameter logic [6:0] CHIP_ADDR   = 7'h39,
    parameter int         MAX_RETRIES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart_n,
    output logic [7:0]  cmd_index,
    input  logic [15:0] cmd_data,
    output logic [6:0]  i2c_chip_addr,
    output logic [7:0]  i2c_reg_addr,
    output logic [7:0]  i2c_value,
    output logic        i2c_enable,
    input  logic        i2c_done,
    input  logic        i2c_ack_error,
    output logic        ready,
    output logic        error
);

    typedef enum logic [2:0] {
        S_ISSUE = 3'd0,
        S_WAIT  = 3'd1,
        S_WAIT2 = 3'd2,
        S_DONE  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    localparam logic [7:0] LAST_INDEX  = 8'(NUM_CMDS);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

    state_t     state;
    logic [3:0] retry_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_ISSUE;
            cmd_index     <= 8'd0;
            ready         <= 1'b0;
            i2c_enable    <= 1'b0;
            i2c_chip_addr <= 7'd0;
            i2c_reg_addr  <= 8'd0;
            i2c_value     <= 8'd0;
            retry_count   <= 4'd0;
`ifdef SEQ_RETRY_LIMIT_EN
            error         <= 1'b0;
`endif
        end else begin
            case (state)
                S_ISSUE: begin
                    if (i2c_done) begin
                        if (cmd_index == LAST_INDEX) begin
                            ready     <= 1'b1;
                            cmd_index <= 8'd0;
                            state     <= S_DONE;
                        end else begin
                            i2c_chip_addr <= CHIP_ADDR;
                            i2c_reg_addr  <= cmd_data[15:8];
                            i2c_value     <= cmd_data[7:0];
                            i2c_enable    <= 1'b1;
                            state         <= S_WAIT;
                        end
                    end
                end
                // Lets the engine drop i2c_done before the result is judged.
                S_WAIT: state <= S_WAIT2;
                S_WAIT2: begin
                    i2c_enable <= 1'b0;
                    if (i2c_done) begin
                        if (!i2c_ack_error) begin
                            cmd_index   <= cmd_index + 8'd1;
                            retry_count <= 4'd0;
                            state       <= S_ISSUE;
                        end else begin
                            if (retry_count != RETRY_LIMIT)
                                retry_count <= retry_count + 4'd1;
`ifdef SEQ_RETRY_LIMIT_EN
                            if (retry_count + 4'd1 >= RETRY_LIMIT) begin
                                error <= 1'b1;
                                state <= S_FAIL;
                            end else begin
                                state <= S_ISSUE;
                            end
`else
                            state <= S_ISSUE;
`endif
                        end
                    end
                end
                S_DONE: begin
                    if (!restart_n) begin
                        ready       <= 1'b0;
                        retry_count <= 4'd0;
                        state       <= S_ISSUE;
                    end
                end
                S_FAIL: begin
                    ready <= 1'b0;
                    if (!restart_n) begin
                        retry_count <= 4'd0;
                        cmd_index   <= 8'd0;
                        state       <= S_ISSUE;
`ifdef SEQ_RETRY_LIMIT_EN
                        error       <= 1'b0;
`endif
                    end
                end
                default: begin
                    i2c_enable <= 1'b0;
                    state      <= S_ISSUE;
                end
            endcase
        end
    end

`ifndef SEQ_RETRY_LIMIT_EN
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb/tb_i2c_reg_sequencer.sv - randomized bench for i2c_reg_sequencer with a transaction-level model
module tb_i2c_reg_sequencer;
    localparam int N    = 4;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        restart_n = 1'b1;
    logic [7:0]  cmd_index;
    logic [15:0] cmd_data;
    logic [6:0]  i2c_chip_addr;
    logic [7:0]  i2c_reg_addr;
    logic [7:0]  i2c_value;
    logic        i2c_enable;
    logic        i2c_done = 1'b1;
    logic        i2c_ack_error = 1'b0;
    logic        ready;
    logic        error;

    logic [15:0] tbl [N];
    assign cmd_data = (cmd_index < 8'(N)) ? tbl[cmd_index[1:0]] : 16'h0000;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.NUM_CMDS(N), .CHIP_ADDR(7'h39), .MAX_RETRIES(MAXR)) dut (
        .clk(clk), .reset(reset), .restart_n(restart_n),
        .cmd_index(cmd_index), .cmd_data(cmd_data),
        .i2c_chip_addr(i2c_chip_addr), .i2c_reg_addr(i2c_reg_addr), .i2c_value(i2c_value),
        .i2c_enable(i2c_enable), .i2c_done(i2c_done), .i2c_ack_error(i2c_ack_error),
        .ready(ready), .error(error)
    );

    int total = 0;
    int bad = 0;
    logic [15:0] wlog [$];
    int  nack_cnt [N];
    bit  perm_nack = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Engine model plus expectation tracker: one sample per cycle, just after the falling edge.
    int cyc = 0, exp_idx = 0, retries = 0, busy = 0, en_run = 0;
    int ready_due = -1, ready_off = -1, err_due = -1, err_off = -1, gap_due = -1, idx_due = -1;
    bit exp_ready = 0, exp_error = 0, prev_rst = 0, prev_en = 0, orphan = 0, cur_nack = 0;
    logic [15:0] cur_w = 16'h0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (prev_rst) begin
                exp_ready = 0; exp_error = 0; exp_idx = 0; retries = 0; en_run = 0;
                ready_due = -1; ready_off = -1; err_due = -1; err_off = -1; gap_due = -1; idx_due = -1;
                chk("reset_data", int'({cmd_index, i2c_reg_addr, i2c_value}), 0);
                chk("reset_ctl", int'({i2c_chip_addr, i2c_enable, ready, error}), 0);
            end
            if (cyc == ready_due) exp_ready = 1;
            if (cyc == ready_off) exp_ready = 0;
            if (cyc == err_due) exp_error = 1;
            if (cyc == err_off) exp_error = 0;
            chk("ready", int'(ready), int'(exp_ready));
            chk("error", int'(error), int'(exp_error));
            chk("index_range", int'(cmd_index <= 8'(N)), 1);
            if (cyc == ready_due) chk("index_wrap", int'(cmd_index), 0);
            if (cyc == idx_due) chk("index_end", int'(cmd_index), N);
            if (cyc == gap_due) chk("issue_latency", int'(i2c_enable && !prev_en), 1);

            if (i2c_enable && !prev_en) begin
                chk("issue_allowed", int'(!exp_ready && !exp_error && busy == 0 && exp_idx < N), 1);
                chk("chip_addr", int'(i2c_chip_addr), 'h39);
                chk("write_word", int'({i2c_reg_addr, i2c_value}),
                    (exp_idx < N) ? int'(tbl[2'(exp_idx)]) : -1);
                cur_w = {i2c_reg_addr, i2c_value};
                wlog.push_back(cur_w);
                if (exp_idx < N && nack_cnt[2'(exp_idx)] > 0) begin
                    cur_nack = 1;
                    nack_cnt[2'(exp_idx)]--;
                end else begin
                    cur_nack = perm_nack;
                end
                busy = $urandom_range(1, 5);
                orphan = 0;
                i2c_done = 1'b0;
            end else if (busy > 0) begin
                if (!orphan) chk("write_stable", int'({i2c_reg_addr, i2c_value}), int'(cur_w));
                busy--;
                if (busy == 0) begin
                    i2c_done = 1'b1;
                    i2c_ack_error = cur_nack;
                    if (!orphan) begin
                        if (!cur_nack) begin
                            exp_idx++;
                            retries = 0;
                            if (exp_idx == N) begin
                                idx_due = cyc + 1;
                                ready_due = cyc + 2;
                            end else begin
                                gap_due = cyc + 2;
                            end
                        end else begin
                            retries++;
`ifdef SEQ_RETRY_LIMIT_EN
                            if (retries >= MAXR) err_due = cyc + 1;
                            else gap_due = cyc + 2;
`else
                            gap_due = cyc + 2;
`endif
                        end
                    end
                end
            end

            if (i2c_enable) begin
                en_run++;
            end else begin
                if (prev_en && en_run != 0) chk("enable_width", en_run, 2);
                en_run = 0;
            end
            prev_en = i2c_enable;

            if (!restart_n && reset && (exp_ready || exp_error)) begin
                if (exp_ready) ready_off = cyc + 1;
                else err_off = cyc + 1;
                exp_idx = 0;
                retries = 0;
                gap_due = cyc + 2;
            end
            prev_rst = !reset;
            if (!reset && busy > 0) orphan = 1;
        end
    end

    task automatic wait_ready(input int bound);
        int n = 0;
        while (!ready && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_writes(input int cnt, input int bound);
        int n = 0;
        while (wlog.size() < cnt && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (wlog.size() < cnt) chk("write_timeout", wlog.size(), cnt);
    endtask

    task automatic start_run(input int low_cycles);
        @(negedge clk);
        wlog.delete();
        restart_n = 1'b0;
        repeat (low_cycles) @(negedge clk);
        restart_n = 1'b1;
    endtask

    task automatic load_plan_table();
        tbl[0] = 16'h4110; tbl[1] = 16'h9803; tbl[2] = 16'h9AE0; tbl[3] = 16'h9C30;
    endtask

    int nsum;
    int n;

    initial begin
        for (int i = 0; i < N; i++) nack_cnt[i] = 0;
        load_plan_table();
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(ready), 0);
        chk("rst_enable", int'(i2c_enable), 0);
        chk("rst_index", int'(cmd_index), 0);
        reset = 1'b1;

        wait_ready(400);
        chk("clean_writes", wlog.size(), 4);
        chk("clean_first", int'(wlog[0]), 'h4110);
        chk("clean_last", int'(wlog[3]), 'h9C30);
        chk("clean_index", int'(cmd_index), 0);

        nack_cnt[1] = 1;
        start_run(1);
        wait_ready(400);
        chk("nack_writes", wlog.size(), 5);
        chk("nack_retry_a", int'(wlog[1]), 'h9803);
        chk("nack_retry_b", int'(wlog[2]), 'h9803);
        chk("nack_next", int'(wlog[3]), 'h9AE0);

        start_run(1);
        wait_writes(3, 400);
        restart_n = 1'b0;
        @(negedge clk);
        restart_n = 1'b1;
        wait_ready(400);
        chk("midrestart_writes", wlog.size(), 4);
        repeat (10) @(negedge clk);
        chk("midrestart_hold", int'(ready), 1);
        chk("midrestart_noreplay", wlog.size(), 4);

        for (int r = 0; r < 6; r++) begin
            nsum = 0;
            for (int i = 0; i < N; i++) begin
                tbl[i] = 16'($urandom);
                nack_cnt[i] = $urandom_range(0, 2);
                nsum += nack_cnt[i];
            end
            start_run($urandom_range(1, 3));
            wait_ready(1000);
            chk("rand_writes", wlog.size(), N + nsum);
        end

        load_plan_table();
        perm_nack = 1'b1;
        start_run(1);
`ifdef SEQ_RETRY_LIMIT_EN
        n = 0;
        while (!error && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("limit_error", int'(error), 1);
        chk("limit_ready", int'(ready), 0);
        chk("limit_writes", wlog.size(), 3);
        chk("limit_word", int'(wlog[2]), 'h4110);
        perm_nack = 1'b0;
        start_run(1);
        chk("limit_cleared", int'(error), 0);
        wait_ready(400);
        chk("limit_replay_writes", wlog.size(), 4);
        chk("limit_replay_first", int'(wlog[0]), 'h4110);
`else
        wait_writes(6, 600);
        chk("unlim_error", int'(error), 0);
        chk("unlim_word", int'(wlog[5]), 'h4110);
        perm_nack = 1'b0;
        wait_ready(600);
        chk("unlim_last", int'(wlog[wlog.size() - 1]), 'h9C30);
        chk("unlim_error_end", int'(error), 0);
`endif

        start_run(1);
        n = 0;
        while (!i2c_enable && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_enable_seen", int'(i2c_enable), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_enable", int'(i2c_enable), 0);
        chk("rst_mid_index", int'(cmd_index), 0);
        chk("rst_mid_addr", int'({i2c_chip_addr, i2c_reg_addr, i2c_value}), 0);
        reset = 1'b1;
        wlog.delete();
        wait_ready(600);
        chk("rst_mid_writes", wlog.size(), 4);
        chk("rst_mid_first", int'(wlog[0]), 'h4110);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Parametrised I2C register-initialisation sequencer for the HDMI transmitter path. It walks an externally supplied command table of `{reg_addr, value}` words and issues one single-register write per entry through the existing byte-write engine. On ACK error it retries the same entry. After the last entry it asserts `ready` and then idles until a restart request (the transmitter's active-low interrupt), which replays the whole table. It sits between the top-level clock/reset and the I2C write engine, replacing the fixed-table init controller.

## Interface
- `NUM_CMDS`, 24: number of table entries; legal range 1..255.
- `CHIP_ADDR`, 7'h39: 7-bit I2C device address driven on every write.
- `MAX_RETRIES`, 3: consecutive ACK failures allowed per entry before error. Used only with `SEQ_RETRY_LIMIT_EN`; legal range 1..15.
- `clk`, in, 1: pixel clock.
- `reset`, in, 1: synchronous reset, active-low; clock is `clk`.
- `restart_n`, in, 1: active-low level restart request (transmitter interrupt).
- `cmd_index`, out, 8: current table index.
- `cmd_data`, in, 16: table word at `cmd_index`; `[15:8]` is the register address, `[7:0]` is the value. Must be combinational from `cmd_index`.
- `i2c_chip_addr`, out, 7: device address to the write engine.
- `i2c_reg_addr`, out, 8: register address to the write engine.
- `i2c_value`, out, 8: data byte to the write engine.
- `i2c_enable`, out, 1: write request to the write engine.
- `i2c_done`, in, 1: write engine idle or finished.
- `i2c_ack_error`, in, 1: last transfer NACKed; valid while `i2c_done` is high.
- `ready`, out, 1: full table written successfully.
- `error`, out, 1: retry limit exhausted (only with `SEQ_RETRY_LIMIT_EN`; otherwise tied 0).

## Operation
- States: S_ISSUE, S_WAIT, S_WAIT2, S_DONE, S_FAIL. Use safe encoding.
- **S_ISSUE**, when `i2c_done` is high:
  - If `cmd_index == NUM_CMDS`: set `ready` to 1, set `cmd_index` to 0, go to S_DONE.
  - Otherwise: latch `cmd_data` into `i2c_reg_addr`/`i2c_value`, drive `CHIP_ADDR` on `i2c_chip_addr`, set `i2c_enable` to 1, go to S_WAIT.
  - If `i2c_done` is low: hold.
- **S_WAIT**: unconditionally go to S_WAIT2. This gives the engine one cycle to drop `i2c_done`.
- **S_WAIT2**: clear `i2c_enable`. When `i2c_done` is high:
  - If `i2c_ack_error` is 0: increment `cmd_index` and clear the retry counter.
  - If `i2c_ack_error` is 1: keep `cmd_index` and increment the retry counter.
  - Then go to S_ISSUE.
- **S_DONE**: if `restart_n` is 0, clear `ready`, clear the retry counter, go to S_ISSUE.
- **S_FAIL**: hold `error` at 1 and `ready` at 0. If `restart_n` is 0, clear `error` and the retry counter, set `cmd_index` to 0, go to S_ISSUE.
- `restart_n` is ignored in S_ISSUE, S_WAIT and S_WAIT2. A restart request during a sequence does not abort it. If the request is still low when S_DONE is reached, the table replays immediately.
- `cmd_index` width is 8 bits and never exceeds `NUM_CMDS`. The retry counter is 4 bits and saturates at `MAX_RETRIES`.

## Timing
- Reset values:
  - `state` = S_ISSUE, `cmd_index` = 0.
  - `ready`, `error`, `i2c_enable` = 0.
  - `i2c_chip_addr`, `i2c_reg_addr`, `i2c_value` = 0.
  - Retry counter = 0.
- Reset asserted mid-transfer returns to these values on the next edge. The write engine is not reset by this block.
- `i2c_enable` is high for exactly 2 cycles per write: the S_WAIT cycle plus the first S_WAIT2 cycle.
- Address and value are stable from the first `i2c_enable` cycle until the next S_ISSUE issue.
- `cmd_data` is sampled in the S_ISSUE cycle, one cycle after `cmd_index` updates.
- Minimum per-entry overhead beyond engine busy time: 3 cycles.
- `ready` rises one cycle after S_ISSUE sees `cmd_index == NUM_CMDS` with `i2c_done` high. It falls one cycle after `restart_n` is sampled low in S_DONE.

## Configuration
- Macro: `SEQ_RETRY_LIMIT_EN`.
- **Defined**: in S_WAIT2, an ACK error that brings the retry counter to `MAX_RETRIES` sets `error` to 1 and goes to S_FAIL instead of S_ISSUE.
- **Undefined**: retries are unbounded (the same entry is retried forever), S_FAIL is unreachable, and `error` is a constant 0.

## Test plan
- **Clean sequence**: `NUM_CMDS`=4, table 0x4110/0x9803/0x9AE0/0x9C30, engine always ACKs.
  - Four writes in order, each with `i2c_chip_addr`=0x39 and a 2-cycle `i2c_enable`.
  - `ready` = 1 after the 4th `i2c_done`.
  - `cmd_index` = 0 in S_DONE.
- **Single NACK**: NACK the 2nd entry once.
  - Entry 1 (0x98/0x03) is issued twice.
  - Sequence completes with 5 writes total and `ready` = 1.
- **Retry limit**: `SEQ_RETRY_LIMIT_EN` defined, `MAX_RETRIES`=3, NACK entry 0 permanently.
  - Exactly 3 writes of 0x41/0x10, then `error` = 1 and `ready` = 0.
  - Pulsing `restart_n` low restarts at index 0 with `error` cleared.
- **Unlimited retries**: macro undefined, same stimulus.
  - Writes continue past 3 attempts and `error` stays 0.
  - Releasing the NACK completes the sequence.
- **Restart**: after `ready`, drive `restart_n` low for 1 cycle → `ready` drops and the full table replays. Drive `restart_n` low during entry 2 → no abort; all 4 entries complete.
- **Reset mid-op**: assert `reset` low while `i2c_enable` is high → all outputs return to their reset values next cycle. After release, writing restarts from index 0.
